// File: rtl/servo_slew_pwm_if.sv
// Servo drive channel bundle: target request, slew controls and PWM/status outputs.
//   target_valid / target_pw : one-cycle strobe and requested pulse width (cycles)
//   step                     : max change of cur_pw per frame, 0 = jump to target
//   hold                     : freeze cur_pw at frame boundaries while high
//   pwm_out                  : registered servo PWM output
//   cur_pw                   : pulse width in effect for the current frame
//   busy                     : high while cur_pw differs from target (one-cycle lag)
//   frame_start              : one-cycle pulse in the first cycle of each frame
interface servo_slew_pwm_if #(
  parameter int unsigned PW_W = 18
);

  logic            target_valid;
  logic [PW_W-1:0] target_pw;
  logic [PW_W-1:0] step;
  logic            hold;
  logic            pwm_out;
  logic [PW_W-1:0] cur_pw;
  logic            busy;
  logic            frame_start;

  // Register-block side: issues targets and slew controls, observes status.
  modport master (
    output target_valid, target_pw, step, hold,
    input  pwm_out, cur_pw, busy, frame_start
  );

  // Drive-stage side.
  modport slave (
    input  target_valid, target_pw, step, hold,
    output pwm_out, cur_pw, busy, frame_start
  );

endinterface

// File: rtl/servo_slew_pwm.sv
// Per-axis servo drive stage. Clamps the requested pulse width into
// [MIN_PW, MAX_PW], slews the active width toward it by at most `step`
// once per PWM frame, and drives a glitch-free PWM whose width only
// changes at frame boundaries.
// Ports:
//   PCLK    : clock
//   PRESERN : asynchronous active-low reset
//   sif     : servo_slew_pwm_if.slave (target strobe, step, hold in;
//             pwm_out, cur_pw, busy, frame_start out)
module servo_slew_pwm #(
  parameter int unsigned PW_W   = 18,
  parameter int unsigned CNT_W  = 21,
  parameter int unsigned PERIOD = 2000000,
  parameter int unsigned MIN_PW = 60000,
  parameter int unsigned MAX_PW = 240000
) (
  input  logic             PCLK,
  input  logic             PRESERN,
  servo_slew_pwm_if.slave  sif
);

  localparam int unsigned CMP_W = (CNT_W > PW_W) ? CNT_W : PW_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [PW_W-1:0]  PW_MIN   = PW_W'(MIN_PW);
  localparam logic [PW_W-1:0]  PW_MAX   = PW_W'(MAX_PW);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RAMP_UP   = 2'b01,
    RAMP_DOWN = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [PW_W-1:0]  target;
  logic [PW_W-1:0]  cur_pw_q;
  logic             pwm_q;
  logic             frame_start_q;

  logic             wrap_c;
  logic [PW_W-1:0]  target_clamp_c;
  logic [PW_W:0]    diff_c;
  logic [PW_W-1:0]  cur_pw_nxt_c;

  assign sif.cur_pw      = cur_pw_q;
  assign sif.pwm_out     = pwm_q;
  assign sif.frame_start = frame_start_q;
  // busy is a decode of the state register alone, so it lags equality by one cycle.
  assign sif.busy        = (state != IDLE);

  // Last cycle of the frame; the boundary edge for slewing.
  assign wrap_c = (cnt == CNT_LAST);

  // Clamp the incoming request into the legal range.
  always_comb begin
    target_clamp_c = sif.target_pw;
    if (sif.target_pw < PW_MIN) begin
      target_clamp_c = PW_MIN;
    end else if (sif.target_pw > PW_MAX) begin
      target_clamp_c = PW_MAX;
    end
  end

  // Distance to target as an unsigned magnitude one bit wider than the operands.
  always_comb begin
    diff_c = '0;
    if (target >= cur_pw_q) begin
      diff_c = {1'b0, target} - {1'b0, cur_pw_q};
    end else begin
      diff_c = {1'b0, cur_pw_q} - {1'b0, target};
    end
  end

  // Bounded step toward target at the frame boundary; the last step is
  // truncated onto target so cur_pw never overshoots or leaves the range.
  always_comb begin
    cur_pw_nxt_c = cur_pw_q;
    if (wrap_c && !sif.hold) begin
      if ((sif.step == '0) || (diff_c <= {1'b0, sif.step})) begin
        cur_pw_nxt_c = target;
      end else if (target > cur_pw_q) begin
        cur_pw_nxt_c = cur_pw_q + sif.step;
      end else begin
        cur_pw_nxt_c = cur_pw_q - sif.step;
      end
    end
  end

  // Frame counter, target capture, slewed width and PWM output.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      cnt           <= '0;
      target        <= PW_MIN;
      cur_pw_q      <= PW_MIN;
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt           <= wrap_c ? '0 : cnt + CNT_W'(1);
      frame_start_q <= wrap_c;
      // Compare uses the width in effect this cycle, so pwm_out is high for
      // exactly cur_pw cycles of the frame, one cycle behind the counter.
      pwm_q         <= (CMP_W'(cnt) < CMP_W'(cur_pw_q));
      cur_pw_q      <= cur_pw_nxt_c;
      if (sif.target_valid) begin
        target <= target_clamp_c;
      end
    end
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ramp direction from the registered target/cur_pw; may flip directly on retarget.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE, RAMP_UP, RAMP_DOWN: begin
        if (target > cur_pw_q) begin
          state_nxt = RAMP_UP;
        end else if (target < cur_pw_q) begin
          state_nxt = RAMP_DOWN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/servo_slew_pwm.md
Name: servo_slew_pwm

Overview:
- Per-axis servo drive stage. It sits between the APB3 servo pulse-width registers (offsets 0x10/0x14) and the servo output pin, and replaces the free-running PWM generator.
- Accepts a target pulse width and clamps it to the legal range.
- Slews the active pulse width toward the target by a bounded step once per PWM frame, so turret moves are smooth.
- Drives a glitch-free PWM output; pulse width changes only at frame boundaries.

Parameters:
- PW_W, 18, width of pulse-width values.
- CNT_W, 21, width of the frame counter (must hold PERIOD-1).
- PERIOD, 2000000, frame length in PCLK cycles (20 ms at 100 MHz).
- MIN_PW, 60000, minimum legal pulse width in cycles.
- MAX_PW, 240000, maximum legal pulse width in cycles.

Ports:
- PCLK  in  1  clock.
- PRESERN  in  1  reset; asynchronous, active-low.
- target_valid  in  1  one-cycle strobe; capture target_pw.
- target_pw  in  PW_W  requested pulse width in cycles.
- step  in  PW_W  maximum change of cur_pw per frame; 0 means jump directly to target.
- hold  in  1  freezes cur_pw at frame boundaries while high.
- pwm_out  out  1  servo PWM output, registered.
- cur_pw  out  PW_W  pulse width in effect for the current frame.
- busy  out  1  high while cur_pw != target.
- frame_start  out  1  one-cycle pulse during the first cycle of each frame (cnt==0).

Behaviour:
- Reset (async, PRESERN low):
  - cnt=0, target=MIN_PW, cur_pw=MIN_PW.
  - pwm_out=0, busy=0, frame_start=0, state=IDLE.
  - Reset asserted mid-frame or mid-ramp forces these values immediately, with no dependence on a clock edge.
- Frame counter:
  - cnt increments every cycle.
  - At cnt==PERIOD-1 it wraps to 0, so a frame is exactly PERIOD cycles.
  - frame_start is registered: high exactly in the cycles where cnt==0.
- PWM output:
  - pwm_out <= (cnt < cur_pw), registered, one cycle latency.
  - Yields exactly cur_pw high cycles per frame.
  - Since cur_pw >= MIN_PW > 0, the output is never constantly low after reset.
- Target capture:
  - On target_valid, target <= clamp(target_pw, MIN_PW, MAX_PW).
  - Unsigned compare.
  - Last strobe wins. There is no backpressure; target_valid is accepted every cycle.
- Slew update (only on the edge where cnt==PERIOD-1, and only if hold==0):
  - If step==0 or |target-cur_pw| <= step: cur_pw <= target. The final step is truncated; no overshoot.
  - Else if target > cur_pw: cur_pw <= cur_pw + step.
  - Else: cur_pw <= cur_pw - step.
  - The difference is computed as PW_W+1 bits unsigned magnitude; the sum cannot exceed MAX_PW because of the truncation rule.
- Simultaneous events:
  - target_valid on the same edge as the frame-boundary update: the update uses the old target. The new target is used at the next boundary.
  - hold==1 at a boundary: cur_pw is unchanged. Target capture still operates.
- State machine (state register updated every cycle from registered target/cur_pw):
  - States: IDLE, RAMP_UP, RAMP_DOWN.
  - Next state: IDLE if target==cur_pw; RAMP_UP if target>cur_pw; RAMP_DOWN if target<cur_pw.
  - A retarget mid-ramp may switch RAMP_UP<->RAMP_DOWN directly.
  - busy = (state != IDLE). busy lags cur_pw/target equality by one cycle.
- cur_pw never leaves [MIN_PW, MAX_PW].

Test Plan (PERIOD=1000, MIN_PW=100, MAX_PW=400, CNT_W=10, PW_W=9):
1. Release reset, no strobe -> every frame has pwm_out high for exactly 100 cycles; cur_pw=100; busy=0; frame_start pulses every 1000 cycles.
2. step=100, strobe target_pw=400 -> cur_pw=200, 300, 400 in successive frames; pwm_out high counts 200/300/400; busy high from cycle after strobe until one cycle after cur_pw reaches 400.
3. Clamp: strobe 50 -> target=100; strobe 500 -> target=400; strobe 399 -> 399.
4. step=0, cur_pw=100, strobe 250 -> next frame cur_pw=250 in one jump; earlier frame remains 100 (no mid-frame change).
5. From 400, step=70, target 100 -> 330, 260. Assert hold for 2 boundaries -> 260, 260. Release hold -> 190, 120, 100 (truncated final step). Strobe 300 while at 190 -> direction reverses: 260, 300.
6. Strobe target_pw on the exact cnt==999 cycle -> that boundary uses the old target; the new target applies at the following boundary. Pull PRESERN low at cnt=500 mid-ramp -> pwm_out=0, cur_pw=100, busy=0 without any clock edge.
